// File: rtl/chs_fan_mode_ctrl.sv
// CHS helper: combinational temperature-to-mode/power decoder beside a free-running 8-bit fan PWM.
// The two halves share no state; only the PWM half is clocked and reset.

module chs_mode_power (
    input  logic [7:0] chs_conf,
    output logic [3:0] chs_power,
    output logic       chs_mode
);

    localparam int unsigned TempW      = 8;
    localparam int unsigned PowerW     = 4;
    localparam logic [TempW-1:0] HeatMax    = TempW'(14);
    localparam logic [TempW-1:0] ComfortMax = TempW'(25);
    localparam logic [TempW-1:0] CoolMax    = TempW'(40);
    localparam logic [TempW-1:0] HeatRef    = TempW'(15);

    // Every 8-bit reading lands in exactly one band; the final else covers saturation.
    always_comb begin
        chs_mode  = 1'b0;
        chs_power = '0;
        if (chs_conf <= HeatMax) begin
            chs_mode  = 1'b0;
            chs_power = PowerW'(HeatRef - chs_conf);
        end else if (chs_conf <= ComfortMax) begin
            chs_mode  = 1'b0;
            chs_power = '0;
        end else if (chs_conf <= CoolMax) begin
            chs_mode  = 1'b1;
            chs_power = PowerW'(chs_conf - ComfortMax);
        end else begin
            chs_mode  = 1'b1;
            chs_power = '1;
        end
    end

endmodule

module chs_fan_speed (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] speed,
    output logic       pwm_data
);

    localparam int unsigned CntW = 8;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
    logic            pwm_q;
    logic            pwm_d;

    // Speed is compared live, so a mid-period change takes effect on the very next edge.
    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        pwm_d = (cnt_q < speed);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_data = pwm_q;

endmodule

module chs_fan_mode_ctrl (
    input  logic       clk,
    input  logic       arst,
    input  logic [7:0] speed,
    input  logic [7:0] chs_conf,
    output logic [3:0] chs_power,
    output logic       chs_mode,
    output logic       pwm_data
);

    chs_mode_power u_mode_power (
        .chs_conf  (chs_conf),
        .chs_power (chs_power),
        .chs_mode  (chs_mode)
    );

    chs_fan_speed u_fan_speed (
        .clk      (clk),
        .arst     (arst),
        .speed    (speed),
        .pwm_data (pwm_data)
    );

endmodule

// File: tb/tb_chs_fan_mode_ctrl.sv
// Directed bench for chs_fan_mode_ctrl: decoder band table plus PWM edge-by-edge duty checks.

module tb_chs_fan_mode_ctrl;

    logic       clk;
    logic       arst;
    logic [7:0] speed;
    logic [7:0] chs_conf;
    logic [3:0] chs_power;
    logic       chs_mode;
    logic       pwm_data;

    int unsigned n_tests;
    int unsigned n_fail;

    chs_fan_mode_ctrl dut (
        .clk       (clk),
        .arst      (arst),
        .speed     (speed),
        .chs_conf  (chs_conf),
        .chs_power (chs_power),
        .chs_mode  (chs_mode),
        .pwm_data  (pwm_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hand-computed decoder table: {conf, mode, power}
    typedef struct {
        logic [7:0] conf;
        logic       mode;
        logic [3:0] power;
    } mp_vec_t;

    mp_vec_t mp_vecs[12];

    task automatic apply_reset();
        @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pwm_in_reset", 32'(pwm_data), 32'd0);
    endtask

    // Release at a falling edge; edge k after release evaluates cnt = (k-1) mod 256.
    task automatic run_pwm(input string tag, input int unsigned n_edges);
        logic exp;
        arst = 1'b0;
        for (int k = 1; k <= int'(n_edges); k++) begin
            @(posedge clk);
            @(negedge clk);
            exp = (32'((k - 1) % 256) < 32'(speed));
            check(tag, 32'(pwm_data), 32'(exp));
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        arst     = 1'b1;
        speed    = 8'h00;
        chs_conf = 8'h00;

        mp_vecs[0]  = '{8'h00, 1'b0, 4'd15};
        mp_vecs[1]  = '{8'h01, 1'b0, 4'd14};
        mp_vecs[2]  = '{8'h02, 1'b0, 4'd13};
        mp_vecs[3]  = '{8'h0E, 1'b0, 4'd1};
        mp_vecs[4]  = '{8'h0F, 1'b0, 4'd0};
        mp_vecs[5]  = '{8'h19, 1'b0, 4'd0};
        mp_vecs[6]  = '{8'h1A, 1'b1, 4'd1};
        mp_vecs[7]  = '{8'h22, 1'b1, 4'd9};
        mp_vecs[8]  = '{8'h28, 1'b1, 4'd15};
        mp_vecs[9]  = '{8'h29, 1'b1, 4'd15};
        mp_vecs[10] = '{8'hBC, 1'b1, 4'd15};
        mp_vecs[11] = '{8'hFF, 1'b1, 4'd15};

        repeat (2) @(negedge clk);
        check("pwm_reset", 32'(pwm_data), 32'd0);

        // Decoder works while the PWM half is held in reset.
        foreach (mp_vecs[i]) begin
            chs_conf = mp_vecs[i].conf;
            #1;
            check($sformatf("mode_%02h", mp_vecs[i].conf), 32'(chs_mode), 32'(mp_vecs[i].mode));
            check($sformatf("power_%02h", mp_vecs[i].conf), 32'(chs_power), 32'(mp_vecs[i].power));
        end
        chs_conf = 8'h10;
        #1;
        check("mode_10", 32'(chs_mode), 32'd0);
        check("power_10", 32'(chs_power), 32'd0);

        // 25 % duty: high on edges 1-64 and 257-320.
        apply_reset();
        speed = 8'h40;
        run_pwm("pwm_25pct", 512);

        // Extremes.
        apply_reset();
        speed = 8'h00;
        run_pwm("pwm_zero", 512);
        apply_reset();
        speed = 8'hFF;
        run_pwm("pwm_max", 512);

        // Asynchronous reset mid-period at cycle 100.
        apply_reset();
        speed = 8'h80;
        run_pwm("pwm_pre_abort", 100);
        check("pwm_before_abort", 32'(pwm_data), 32'd1);
        @(posedge clk);
        #2;
        arst = 1'b1;
        #1;
        check("pwm_async_drop", 32'(pwm_data), 32'd0);
        @(negedge clk);
        check("pwm_held_low", 32'(pwm_data), 32'd0);
        run_pwm("pwm_after_abort", 256);

        // Live speed change at cnt = 0x20.
        apply_reset();
        speed = 8'h10;
        arst  = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k <= 32)
                check("pwm_live_pre", 32'(pwm_data), 32'((k - 1) < 16));
            else
                check("pwm_live_post", 32'(pwm_data), 32'(((k - 1) % 256) < 240));
            if (k == 32)
                speed = 8'hF0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
